// File: rtl/aidc_lite_concat_arbiter_if.sv
// Bundles the lane-side request bus, the concatenator-side beat bus and the
// block-result signals of aidc_lite_concat_arbiter.
//   slave  : arbiter view (requests, done_i, fail_i in; ready, beats, result out)
//   master : environment view (lanes and concatenator)
interface aidc_lite_concat_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 66,
  parameter int unsigned ID_W      = 3
);
  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ-1:0]           req_sop_i;
  logic [NUM_REQ-1:0]           req_eop_i;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data_i;
  logic [NUM_REQ*7-1:0]         req_size_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic                         valid_o;
  logic                         sop_o;
  logic                         eop_o;
  logic [DATA_SIZE-1:0]         data_o;
  logic [6:0]                   size_o;
  logic                         done_i;
  logic                         fail_i;
  logic                         rsp_valid_o;
  logic [ID_W-1:0]              rsp_id_o;
  logic                         rsp_fail_o;
  logic                         busy_o;
  logic                         proto_err_o;

  modport slave (
    input  req_valid_i, req_sop_i, req_eop_i, req_data_i, req_size_i, done_i, fail_i,
    output req_ready_o, valid_o, sop_o, eop_o, data_o, size_o,
           rsp_valid_o, rsp_id_o, rsp_fail_o, busy_o, proto_err_o
  );

  modport master (
    output req_valid_i, req_sop_i, req_eop_i, req_data_i, req_size_i, done_i, fail_i,
    input  req_ready_o, valid_o, sop_o, eop_o, data_o, size_o,
           rsp_valid_o, rsp_id_o, rsp_fail_o, busy_o, proto_err_o
  );
endinterface

// File: rtl/aidc_lite_concat_arbiter.sv
// Round-robin, packet-granular arbiter sharing one code-concatenation datapath
// among NUM_REQ encoder lanes. The grant is locked from sop to eop and held
// until the concatenator reports block completion, then a one-cycle result
// (owner id, fail) is returned and the grant released.
// Ports: clk, rst_n (async active-low), bus (aidc_lite_concat_arbiter_if.slave):
//   req_*_i / req_ready_o : per-lane beat handshake
//   valid_o/sop_o/eop_o/data_o/size_o : beats to the concatenator (1-cycle latency)
//   done_i/fail_i : concatenator completion level and fail flag
//   rsp_valid_o/rsp_id_o/rsp_fail_o : per-block result; busy_o, proto_err_o status
// Optional: define AIDC_LITE_CONCAT_ARB_WDOG_EN to add a 255-cycle done_i watchdog.
module aidc_lite_concat_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 66,
  parameter int unsigned ID_W      = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  aidc_lite_concat_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SZ_W  = 7;

  // FLUSH is the cycle the eop beat sits on valid_o; done_i is not yet meaningful.
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_WAIT} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic                 first_q, first_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [SZ_W-1:0]      size_q, size_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_fail_q, rsp_fail_d;
  logic                 busy_q, busy_d;
  logic                 proto_err_q, proto_err_d;
`ifdef AIDC_LITE_CONCAT_ARB_WDOG_EN
  logic [7:0]           wdog_q, wdog_d;
`endif

  logic [NUM_REQ-1:0]   cand;
  logic                 found;
  logic [PTR_W-1:0]     win;
  logic                 accept;
  logic                 sel_sop, sel_eop;
  logic [DATA_SIZE-1:0] sel_data;
  logic [SZ_W-1:0]      sel_size;

  // Granted-lane beat select and round-robin winner search.
  always_comb begin
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    sel_data = '0;
    sel_size = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_sop  = bus.req_sop_i[i];
        sel_eop  = bus.req_eop_i[i];
        sel_data = bus.req_data_i[i*DATA_SIZE +: DATA_SIZE];
        sel_size = bus.req_size_i[i*SZ_W +: SZ_W];
      end
    end
    accept = |(bus.req_valid_i & ready_q);

    cand  = bus.req_valid_i & bus.req_sop_i;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      automatic int idx = int'(ptr_q) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!found && cand[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    first_d     = first_q;
    ready_d     = '0;
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    data_d      = data_q;
    size_d      = size_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_fail_d  = rsp_fail_q;
    proto_err_d = proto_err_q;
`ifdef AIDC_LITE_CONCAT_ARB_WDOG_EN
    wdog_d      = wdog_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (|(bus.req_valid_i & ~bus.req_sop_i)) proto_err_d = 1'b1;
        if (found) begin
          state_d = S_STREAM;
          grant_d = ID_W'(win);
          ptr_d   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
          first_d = 1'b1;
          ready_d = NUM_REQ'(1) << win;
        end
      end
      S_STREAM: begin
        ready_d = ready_q;
        if (accept) begin
          valid_d = 1'b1;
          sop_d   = sel_sop;
          eop_d   = sel_eop;
          data_d  = sel_data;
          size_d  = sel_size;
          first_d = 1'b0;
          // sop must mark exactly the first beat; beat is forwarded regardless.
          if (sel_sop != first_q) proto_err_d = 1'b1;
          if (sel_eop) begin
            state_d = S_FLUSH;
            ready_d = '0;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_WAIT;
`ifdef AIDC_LITE_CONCAT_ARB_WDOG_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        if (bus.done_i) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = grant_q;
          rsp_fail_d  = bus.fail_i;
          state_d     = S_IDLE;
        end
`ifdef AIDC_LITE_CONCAT_ARB_WDOG_EN
        // 255th WAIT cycle without done_i: force a failed result.
        else if (wdog_q == 8'd254) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = grant_q;
          rsp_fail_d  = 1'b1;
          proto_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      first_q     <= 1'b0;
      ready_q     <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
      size_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_fail_q  <= 1'b0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef AIDC_LITE_CONCAT_ARB_WDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      first_q     <= first_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      data_q      <= data_d;
      size_q      <= size_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_fail_q  <= rsp_fail_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
`ifdef AIDC_LITE_CONCAT_ARB_WDOG_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.valid_o     = valid_q;
  assign bus.sop_o       = sop_q;
  assign bus.eop_o       = eop_q;
  assign bus.data_o      = data_q;
  assign bus.size_o      = size_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_id_o    = rsp_id_q;
  assign bus.rsp_fail_o  = rsp_fail_q;
  assign bus.busy_o      = busy_q;
  assign bus.proto_err_o = proto_err_q;
endmodule
